// File: rtl/inj_stage_pkg.sv
// Shared types and helpers for the injection stage: flit type and idle-channel priority encoder.
`ifndef DATA_WIDTH_XBAR
`define DATA_WIDTH_XBAR 8
`endif
`ifndef NUM_PORT
`define NUM_PORT 5
`endif

package inj_stage_pkg;

  localparam int unsigned NUM_LINK = 4;
  localparam int unsigned FLIT_W   = `DATA_WIDTH_XBAR;

  typedef logic [FLIT_W-1:0] flit_t;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } chan_sel_t;

  // Lowest-index idle channel wins; scanning downward lets the last hit be the lowest.
  function automatic chan_sel_t first_idle(input logic [NUM_LINK-1:0] valid);
    chan_sel_t s;
    logic [NUM_LINK-1:0] idle;
    s.found = 1'b0;
    s.idx   = '0;
    idle    = ~valid;
    for (int unsigned k = NUM_LINK; k > 0; k--) begin
      if (idle[k-1]) begin
        s.found = 1'b1;
        s.idx   = 2'(k-1);
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/inj_fifo.sv
// Injection FIFO: power-of-two depth, pointers wrap naturally, occupancy counter drives full/empty.
module inj_fifo
  import inj_stage_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  flit_t                    wdata,
  output flit_t                    rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  flit_t          mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    cnt;
  logic           do_push;
  logic           do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rdata   = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/inj_stage.sv
// Link register stage that slots locally injected flits into idle link channels,
// with a starvation monitor for the injection queue.
module inj_stage
  import inj_stage_pkg::*;
#(
  parameter int unsigned INJ_DEPTH    = 4,
  parameter int unsigned STARVE_LIMIT = 15
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [`DATA_WIDTH_XBAR-1:0]  in_0,
  input  logic [`DATA_WIDTH_XBAR-1:0]  in_1,
  input  logic [`DATA_WIDTH_XBAR-1:0]  in_2,
  input  logic [`DATA_WIDTH_XBAR-1:0]  in_3,
  input  logic [3:0]                   in_valid,
  input  logic [`DATA_WIDTH_XBAR-1:0]  inj_flit,
  input  logic                         inj_valid,
  output logic                         inj_ready,
  output logic [`DATA_WIDTH_XBAR-1:0]  out_0,
  output logic [`DATA_WIDTH_XBAR-1:0]  out_1,
  output logic [`DATA_WIDTH_XBAR-1:0]  out_2,
  output logic [`DATA_WIDTH_XBAR-1:0]  out_3,
  output logic [3:0]                   out_valid,
  output logic [$clog2(INJ_DEPTH):0]   inj_count,
  output logic                         starve
);

  localparam logic [7:0] LIMIT8 = 8'(STARVE_LIMIT);

  flit_t      link_in  [NUM_LINK];
  flit_t      out_q    [NUM_LINK];
  flit_t      out_nxt  [NUM_LINK];
  logic [3:0] vld_q;
  logic [3:0] vld_nxt;
  flit_t      head;
  logic       fifo_full;
  logic       fifo_empty;
  chan_sel_t  sel;
  logic       inject;
  logic [7:0] starve_cnt;
  logic [7:0] starve_nxt;
  logic       starve_q;

  assign link_in[0] = in_0;
  assign link_in[1] = in_1;
  assign link_in[2] = in_2;
  assign link_in[3] = in_3;

  assign sel       = first_idle(in_valid);
  assign inject    = sel.found && !fifo_empty;
  assign inj_ready = !fifo_full;

  inj_fifo #(
    .DEPTH (INJ_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (inj_valid),
    .pop   (inject),
    .wdata (inj_flit),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (inj_count)
  );

  always_comb begin
    for (int unsigned k = 0; k < NUM_LINK; k++) begin
      out_nxt[k] = '0;
      vld_nxt[k] = 1'b0;
      if (in_valid[k]) begin
        out_nxt[k] = link_in[k];
        vld_nxt[k] = 1'b1;
      end else if (inject && (sel.idx == 2'(k))) begin
        out_nxt[k] = head;
        vld_nxt[k] = 1'b1;
      end
    end
  end

  always_comb begin
    starve_nxt = starve_cnt;
    if (inject || fifo_empty) begin
      starve_nxt = '0;
    end else if (&in_valid && (starve_cnt < LIMIT8)) begin
      starve_nxt = starve_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < NUM_LINK; k++) out_q[k] <= '0;
      vld_q      <= '0;
      starve_cnt <= '0;
      starve_q   <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < NUM_LINK; k++) out_q[k] <= out_nxt[k];
      vld_q      <= vld_nxt;
      starve_cnt <= starve_nxt;
      starve_q   <= (starve_nxt == LIMIT8);
    end
  end

  assign out_0     = out_q[0];
  assign out_1     = out_q[1];
  assign out_2     = out_q[2];
  assign out_3     = out_q[3];
  assign out_valid = vld_q;
  assign starve    = starve_q;

endmodule

// File: tb/tb_inj_stage.sv
// Scoreboard bench for inj_stage: a queue-based reference model predicts each cycle's registered
// outputs, and an independent monitor compares them after every clock edge.
`ifndef DATA_WIDTH_XBAR
`define DATA_WIDTH_XBAR 8
`endif

module tb_inj_stage;
  import inj_stage_pkg::*;

  localparam int DEPTH = 4;
  localparam int LIMIT = 15;

  logic                         clk;
  logic                         reset;
  logic [`DATA_WIDTH_XBAR-1:0]  in_0, in_1, in_2, in_3;
  logic [3:0]                   in_valid;
  logic [`DATA_WIDTH_XBAR-1:0]  inj_flit;
  logic                         inj_valid;
  logic                         inj_ready;
  logic [`DATA_WIDTH_XBAR-1:0]  out_0, out_1, out_2, out_3;
  logic [3:0]                   out_valid;
  logic [2:0]                   inj_count;
  logic                         starve;

  inj_stage #(
    .INJ_DEPTH    (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_0      (in_0),
    .in_1      (in_1),
    .in_2      (in_2),
    .in_3      (in_3),
    .in_valid  (in_valid),
    .inj_flit  (inj_flit),
    .inj_valid (inj_valid),
    .inj_ready (inj_ready),
    .out_0     (out_0),
    .out_1     (out_1),
    .out_2     (out_2),
    .out_3     (out_3),
    .out_valid (out_valid),
    .inj_count (inj_count),
    .starve    (starve)
  );

  typedef struct packed {
    logic [3:0][FLIT_W-1:0] d;
    logic [3:0]             v;
    logic [2:0]             cnt;
    logic                   rdy;
    logic                   st;
  } exp_t;

  exp_t  expq [$];
  flit_t mq [$];
  int    scnt;
  int    n_pass;
  int    n_total;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Drive one cycle of inputs and record what the outputs must look like after the edge.
  task automatic step(input logic rst, input logic [3:0] iv,
                      input flit_t a0, input flit_t a1, input flit_t a2, input flit_t a3,
                      input logic pv, input flit_t pf);
    exp_t  e;
    flit_t lk [4];
    int    pre;
    bit    injected;
    @(negedge clk);
    reset = rst; in_valid = iv;
    in_0 = a0; in_1 = a1; in_2 = a2; in_3 = a3;
    inj_valid = pv; inj_flit = pf;
    lk[0] = a0; lk[1] = a1; lk[2] = a2; lk[3] = a3;
    e = '0;
    if (rst) begin
      mq.delete();
      scnt = 0;
    end else begin
      pre = mq.size();
      injected = 0;
      for (int k = 0; k < 4; k++) begin
        if (iv[k]) begin
          e.d[k] = lk[k]; e.v[k] = 1'b1;
        end else if (pre > 0 && !injected) begin
          e.d[k] = mq[0]; e.v[k] = 1'b1; injected = 1;
        end
      end
      if (injected) void'(mq.pop_front());
      if (pv && pre < DEPTH) mq.push_back(pf);
      if (injected || pre == 0) scnt = 0;
      else if (iv == 4'hF) scnt = (scnt + 1 > LIMIT) ? LIMIT : scnt + 1;
    end
    e.cnt = 3'(mq.size());
    e.rdy = (mq.size() < DEPTH);
    e.st  = (scnt == LIMIT);
    expq.push_back(e);
  endtask

  task automatic idle(input logic [3:0] iv);
    step(1'b0, iv, 8'h10, 8'h11, 8'h12, 8'h13, 1'b0, 8'h00);
  endtask

  task automatic push(input logic [3:0] iv, input flit_t f);
    step(1'b0, iv, 8'h20, 8'h21, 8'h22, 8'h23, 1'b1, f);
  endtask

  // Monitor: independent of stimulus, compares each edge's outputs with the next prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("out_valid", 32'(out_valid), 32'(e.v));
        chk("out_0", 32'(out_0), 32'(e.d[0]));
        chk("out_1", 32'(out_1), 32'(e.d[1]));
        chk("out_2", 32'(out_2), 32'(e.d[2]));
        chk("out_3", 32'(out_3), 32'(e.d[3]));
        chk("inj_count", 32'(inj_count), 32'(e.cnt));
        chk("inj_ready", 32'(inj_ready), 32'(e.rdy));
        chk("starve", 32'(starve), 32'(e.st));
      end
    end
  end

  initial begin
    logic [3:0] iv;
    n_pass = 0; n_total = 0; scnt = 0;
    reset = 1'b1; in_valid = '0; inj_valid = 1'b0; inj_flit = '0;
    in_0 = '0; in_1 = '0; in_2 = '0; in_3 = '0;

    step(1'b1, 4'h0, 8'h0, 8'h0, 8'h0, 8'h0, 1'b0, 8'h0);
    step(1'b1, 4'h0, 8'h0, 8'h0, 8'h0, 8'h0, 1'b0, 8'h0);

    // Pass-through of link flits on channels 1 and 3
    step(1'b0, 4'b1010, 8'h00, 8'hA1, 8'h00, 8'hA3, 1'b0, 8'h00);

    // Single push then injection on out_0
    push(4'h0, 8'h55);
    idle(4'h0);
    idle(4'h0);

    // Fill with all links busy, ignored fifth push, then injection on out_3
    for (int i = 0; i < 4; i++) push(4'hF, flit_t'(8'hC0 + i));
    push(4'hF, 8'hCF);
    idle(4'b0111);

    // Refill to full, then push while popping: push refused, count 3
    push(4'hF, 8'hD0);
    push(4'b0111, 8'hD1);
    for (int i = 0; i < 5; i++) idle(4'h0);

    // Starvation: one queued flit blocked 15 cycles, then released on out_0
    push(4'hF, 8'hE5);
    for (int i = 0; i < 15; i++) idle(4'hF);
    idle(4'b1110);
    idle(4'hF);

    // Reset mid-operation with queued flits; none may reappear
    push(4'hF, 8'hF1);
    push(4'hF, 8'hF2);
    push(4'hF, 8'hF3);
    step(1'b1, 4'hF, 8'h30, 8'h31, 8'h32, 8'h33, 1'b1, 8'hF4);
    for (int i = 0; i < 4; i++) idle(4'h0);

    // Randomized traffic biased toward busy links to exercise full and starve
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 3))
        0:       iv = 4'hF;
        1:       iv = 4'hF ^ (4'h1 << $urandom_range(0, 3));
        default: iv = 4'($urandom);
      endcase
      if ((i / 100) % 3 == 1) iv = 4'hF;
      step($urandom_range(0, 199) == 0, iv,
           flit_t'($urandom), flit_t'($urandom), flit_t'($urandom), flit_t'($urandom),
           $urandom_range(0, 9) < 7, flit_t'($urandom));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(expq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
